// File: rtl/pll_lock_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_pkg
// Shared definitions for the PLL lock sequencer: state encoding, default
// timing parameters and small arithmetic helpers used by the sequencer.
// -----------------------------------------------------------------------------
package pll_lock_sequencer_pkg;

    // Sequencer states; the numeric values are visible on the debug port.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_SYNC_STAGES   = 2;

    localparam logic [7:0] EVENT_COUNT_MAX = 8'd255;

    // Largest of three cycle counts; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Increment that sticks at the maximum instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == EVENT_COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer that brings a single asynchronous level into the
// clock domain. The chain clears to 0 on reset.
//
// Ports:
//   clock - destination clock
//   reset - asynchronous active-high reset
//   d     - asynchronous input level
//   q     - synchronized level (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the raw level through the flop chain, oldest sample at the top.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Drives the PLL reset, waits for a synchronized lock that stays asserted
// long enough, then releases the downstream system reset. Lock timeouts send
// the PLL back into reset; lock loss while running does the same. Both events
// are counted with saturating 8-bit counters.
//
// Ports:
//   clock       - free-running reference clock (sole clock)
//   reset       - asynchronous active-high reset
//   enable      - 0 holds the PLL in reset, 1 permits sequencing
//   pll_lock    - raw PLL lock, asynchronous to clock
//   pll_reset   - PLL reset, active-high, registered
//   sys_reset   - reset for PLL-clocked logic, active-high, registered
//   ready       - high only in RUN, registered
//   retry_count - saturating count of lock timeouts
//   loss_count  - saturating count of lock losses in RUN
//   state       - current state encoding for debug
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count,
    output logic [1:0] state
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal values: each phase lasts exactly its parameter in cycles,
    // counting from 0 on entry.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    seq_state_t       state_r;
    seq_state_t       next_state_s;
    logic [CNT_W-1:0] count_r;
    logic             cnt_clear_s;
    logic             cnt_inc_s;
    logic             retry_inc_s;
    logic             loss_inc_s;
    logic             lock_s;

    logic             pll_reset_s;
    logic             sys_reset_s;
    logic             ready_s;
    logic             pll_reset_r;
    logic             sys_reset_r;
    logic             ready_r;
    logic [7:0]       retry_count_r;
    logic [7:0]       loss_count_r;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= PLL_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decision plus counter and event-count actions. enable=0 is
    // checked first so it overrides lock loss and timeout; lock is checked
    // before timeout in WAIT_LOCK so a coincident lock wins.
    always_comb begin
        next_state_s = state_r;
        cnt_clear_s  = 1'b0;
        cnt_inc_s    = 1'b0;
        retry_inc_s  = 1'b0;
        loss_inc_s   = 1'b0;
        case (state_r)
            PLL_RST: begin
                if (!enable) begin
                    cnt_clear_s = 1'b1;
                end else if (count_r == RST_LAST) begin
                    next_state_s = WAIT_LOCK;
                    cnt_clear_s  = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (!enable) begin
                    next_state_s = PLL_RST;
                    cnt_clear_s  = 1'b1;
                end else if (lock_s) begin
                    next_state_s = STABLE;
                    cnt_clear_s  = 1'b1;
                end else if (count_r == TIMEOUT_LAST) begin
                    next_state_s = PLL_RST;
                    cnt_clear_s  = 1'b1;
                    retry_inc_s  = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            STABLE: begin
                if (!enable) begin
                    next_state_s = PLL_RST;
                    cnt_clear_s  = 1'b1;
                end else if (!lock_s) begin
                    // A glitch restarts the timeout window from zero.
                    next_state_s = WAIT_LOCK;
                    cnt_clear_s  = 1'b1;
                end else if (count_r == STABLE_LAST) begin
                    next_state_s = RUN;
                    cnt_clear_s  = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    next_state_s = PLL_RST;
                    cnt_clear_s  = 1'b1;
                end else if (!lock_s) begin
                    next_state_s = PLL_RST;
                    cnt_clear_s  = 1'b1;
                    loss_inc_s   = 1'b1;
                end else begin
                    cnt_clear_s = 1'b1;
                end
            end
            default: begin
                next_state_s = PLL_RST;
                cnt_clear_s  = 1'b1;
            end
        endcase
    end

    // Output decode from the state being entered, so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        pll_reset_s = 1'b1;
        sys_reset_s = 1'b1;
        ready_s     = 1'b0;
        case (next_state_s)
            PLL_RST: begin
                pll_reset_s = 1'b1;
                sys_reset_s = 1'b1;
                ready_s     = 1'b0;
            end
            WAIT_LOCK, STABLE: begin
                pll_reset_s = 1'b0;
                sys_reset_s = 1'b1;
                ready_s     = 1'b0;
            end
            RUN: begin
                pll_reset_s = 1'b0;
                sys_reset_s = 1'b0;
                ready_s     = 1'b1;
            end
            default: begin
                pll_reset_s = 1'b1;
                sys_reset_s = 1'b1;
                ready_s     = 1'b0;
            end
        endcase
    end

    // Shared phase counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cnt_clear_s) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pll_reset_r <= 1'b1;
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            pll_reset_r <= pll_reset_s;
            sys_reset_r <= sys_reset_s;
            ready_r     <= ready_s;
        end
    end

    // Saturating timeout and lock-loss event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_count_r <= 8'd0;
            loss_count_r  <= 8'd0;
        end else begin
            if (retry_inc_s) begin
                retry_count_r <= sat_inc8(retry_count_r);
            end else begin
                retry_count_r <= retry_count_r;
            end
            if (loss_inc_s) begin
                loss_count_r <= sat_inc8(loss_count_r);
            end else begin
                loss_count_r <= loss_count_r;
            end
        end
    end

    assign pll_reset   = pll_reset_r;
    assign sys_reset   = sys_reset_r;
    assign ready       = ready_r;
    assign retry_count = retry_count_r;
    assign loss_count  = loss_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed scenarios for lock timing, timeouts, lock loss, glitches, enable
// and asynchronous reset, followed by randomized lock/enable traffic. Every
// cycle the DUT outputs are compared with a behavioural model that tracks the
// phase and cycles spent in it, with the lock synchronizer modelled as a
// plain sample delay.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_C = 16;
    localparam int LT    = 100;
    localparam int SC    = 1024;
    localparam int SS    = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] loss_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: phase 0..3 as the debug encoding, cycles held in phase, events.
    int         m_phase;
    int         m_held;
    int         m_retry;
    int         m_loss;
    logic [SS-1:0] m_hist;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .retry_count (retry_count),
        .loss_count  (loss_count),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_held  = 0;
        m_retry = 0;
        m_loss  = 0;
        m_hist  = '0;
    endtask

    // One clock edge of the behavioural model, using the pre-edge inputs.
    task automatic model_edge(input logic en, input logic raw);
        logic ls;
        ls = m_hist[SS-1];
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = raw;
        if (m_phase == 0) begin
            if (!en) m_held = 0;
            else begin
                m_held++;
                if (m_held == RST_C) begin m_phase = 1; m_held = 0; end
            end
        end else if (!en) begin
            m_phase = 0; m_held = 0;
        end else if (m_phase == 1) begin
            if (ls) begin m_phase = 2; m_held = 0; end
            else begin
                m_held++;
                if (m_held == LT) begin
                    m_phase = 0; m_held = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
        end else if (m_phase == 2) begin
            if (!ls) begin m_phase = 1; m_held = 0; end
            else begin
                m_held++;
                if (m_held == SC) begin m_phase = 3; m_held = 0; end
            end
        end else begin
            if (!ls) begin
                m_phase = 0; m_held = 0;
                if (m_loss < 255) m_loss++;
            end
        end
    endtask

    task automatic compare_outputs();
        check_value("pll_reset",   pll_reset,   m_phase == 0);
        check_value("sys_reset",   sys_reset,   m_phase != 3);
        check_value("ready",       ready,       m_phase == 3);
        check_value("state",       state,       m_phase);
        check_value("retry_count", retry_count, m_retry);
        check_value("loss_count",  loss_count,  m_loss);
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        model_edge(enable, pll_lock);
        compare_outputs();
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        repeat (hold) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t_ev;
        int rises;
        int last_rise;
        logic prev_pr;
        int budget;
        int len;
        int mode;

        reset    = 1'b1;
        enable   = 1'b1;
        pll_lock = 1'b0;

        // Reset hold time, then lock -> ready latency.
        apply_reset(3);
        t0 = cyc;
        while (pll_reset === 1'b1 && cyc - t0 < 200) tick();
        check_value("pll_reset_hold", cyc - t0, RST_C);
        repeat (60) tick();
        pll_lock = 1'b1;
        t_ev = cyc + 1;
        while (ready !== 1'b1 && cyc - t_ev < 3000) tick();
        check_value("lock_to_ready", cyc - t_ev, SC + 2);
        check_value("sys_reset_at_ready", sys_reset, 1'b0);

        // One-cycle lock drop in RUN.
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        t_ev = cyc;
        while (sys_reset !== 1'b1 && cyc - t_ev < 10) tick();
        check_value("loss_sys_reset_latency", cyc - t_ev, 2);
        check_value("loss_count_after_drop", loss_count, 8'd1);
        while (ready !== 1'b1 && cyc - t_ev < 3000) tick();
        check_value("loss_relock_ready", cyc - t_ev, 2 + RST_C + 1 + SC);

        // enable=0 together with lock drop in RUN: enable wins.
        enable   = 1'b0;
        pll_lock = 1'b0;
        tick();
        check_value("enable_drop_state", state, 2'd0);
        check_value("enable_drop_loss", loss_count, 8'd1);
        repeat (30) tick();
        check_value("enable_hold_pll_reset", pll_reset, 1'b1);
        enable   = 1'b1;
        pll_lock = 1'b1;
        t0 = cyc;
        while (pll_reset === 1'b1 && cyc - t0 < 200) tick();
        check_value("enable_rst_hold", cyc - t0, RST_C);

        // Glitch at STABLE count 500.
        while (state !== 2'd2 && cyc - t0 < 200) tick();
        check_value("reach_stable", state, 2'd2);
        repeat (500) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        t_ev = cyc;
        tick();
        tick();
        check_value("glitch_back_to_wait", state, 2'd1);
        while (ready !== 1'b1 && cyc - t_ev < 3000) tick();
        check_value("glitch_fresh_stable", cyc - t_ev, 3 + SC);

        // Asynchronous reset in the middle of STABLE.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        t0 = cyc;
        while (state !== 2'd2 && cyc - t0 < 200) tick();
        repeat (200) tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check_value("async_reset_state", state, 2'd0);
        check_value("async_reset_pll_reset", pll_reset, 1'b1);
        #2;
        reset = 1'b0;

        // Timeouts with lock held low: re-pulse period and saturation.
        pll_lock  = 1'b0;
        t0        = cyc;
        last_rise = t0;
        rises     = 0;
        prev_pr   = 1'b1;
        repeat (260 * (RST_C + LT) + 50) begin
            tick();
            if (pll_reset === 1'b1 && prev_pr === 1'b0) begin
                rises++;
                if (rises <= 5) check_value("repulse_period", cyc - last_rise, RST_C + LT);
                check_value("retry_on_repulse", retry_count, (rises > 255) ? 255 : rises);
                last_rise = cyc;
            end
            prev_pr = pll_reset;
        end
        check_value("repulse_count", rises, 260);
        check_value("retry_saturated", retry_count, 8'd255);

        // Randomized lock/enable traffic with occasional resets.
        apply_reset(2);
        enable = 1'b1;
        budget = 20000;
        while (budget > 0) begin
            mode = $urandom_range(0, 15);
            if (mode == 0) begin
                enable = 1'b0;
                len    = $urandom_range(1, 40);
            end else if (mode == 1) begin
                apply_reset(1);
                len = 1;
            end else if (mode <= 4) begin
                enable   = 1'b1;
                pll_lock = ~pll_lock;
                len      = $urandom_range(1, 3);
            end else begin
                enable   = 1'b1;
                pll_lock = ($urandom_range(0, 3) != 0);
                len      = $urandom_range(1, 1300);
            end
            repeat (len) tick();
            budget -= len;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
